// File: rtl/ramb_pkg.sv
// ---------------------------------------------------------------------------
// ramb_pkg
// Shared types and helpers for the parametrised true-dual-port block RAM.
//   write_mode_e : per-port write mode (WF write-first, RF read-first,
//                  NC no-change)
//   mode_valid   : true when a mode string is one of the three legal names
//   str_to_mode  : maps the mode string parameter onto write_mode_e
//   lane_merge   : overlays new_word onto old_word wherever the owning lane
//                  enable is set; vectors are carried at MAX_DW bits and the
//                  caller casts to its own width
// ---------------------------------------------------------------------------
package ramb_pkg;

  typedef enum logic [1:0] {WF, RF, NC} write_mode_e;

  localparam int MAX_DW = 256;
  localparam int IDX_W  = 8;   // log2(MAX_DW)

  typedef logic [MAX_DW-1:0] wide_t;

  function automatic bit mode_valid(input string s);
    return (s == "WRITE_FIRST") || (s == "READ_FIRST") || (s == "NO_CHANGE");
  endfunction

  function automatic write_mode_e str_to_mode(input string s);
    if (s == "READ_FIRST") return RF;
    if (s == "NO_CHANGE")  return NC;
    return WF;
  endfunction

  function automatic wide_t lane_merge(input wide_t old_word,
                                       input wide_t new_word,
                                       input wide_t we,
                                       input int    byte_width);
    wide_t r;
    r = old_word;
    for (int b = 0; b < MAX_DW; b++) begin
      if (we[IDX_W'(b / byte_width)]) r[IDX_W'(b)] = new_word[IDX_W'(b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ramb_port_out.sv
// ---------------------------------------------------------------------------
// ramb_port_out
// Output side of one RAM port: output latch with SSR, write-mode selection,
// optional second register stage and the matching data-valid pipeline.
// Ports:
//   clk, rst_n     : clock, async active-low reset (outputs go to INIT)
//   en, wr, ssr    : port enable, "some lane is writing", sync set/reset
//   old_word       : array content at the port address before this edge
//   new_word       : word the array holds at that address after this edge
//   dout, dv       : read data and one-cycle valid flag
// ---------------------------------------------------------------------------
module ramb_port_out
  import ramb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 18,
  parameter write_mode_e           MODE       = WF,
  parameter int                    DO_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr,
  input  logic                  ssr,
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_word,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dv
);

  logic [DATA_WIDTH-1:0] latch_d, latch_q;
  logic                  lv_d, lv_q;

  always_comb begin
    latch_d = latch_q;
    lv_d    = 1'b0;
    if (en) begin
      if (ssr) begin
        latch_d = SRVAL;
      end else if (!wr) begin
        latch_d = old_word;
        lv_d    = 1'b1;
      end else begin
        case (MODE)
          WF: begin
            latch_d = new_word;
            lv_d    = 1'b1;
          end
          RF: begin
            latch_d = old_word;
            lv_d    = 1'b1;
          end
          default: ;  // NC: latch holds, no valid
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q <= INIT;
      lv_q    <= 1'b0;
    end else begin
      latch_q <= latch_d;
      lv_q    <= lv_d;
    end
  end

  if (DO_REG != 0) begin : g_do_reg
    logic [DATA_WIDTH-1:0] dreg_q;
    logic                  dv_q;

    // SSR clears both stages on the same edge so no stale word leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dreg_q <= INIT;
        dv_q   <= 1'b0;
      end else if (en && ssr) begin
        dreg_q <= SRVAL;
        dv_q   <= 1'b0;
      end else begin
        dreg_q <= latch_q;
        dv_q   <= lv_q;
      end
    end

    assign dout = dreg_q;
    assign dv   = dv_q;
  end else begin : g_no_reg
    assign dout = latch_q;
    assign dv   = lv_q;
  end

endmodule

// File: rtl/ramb_tdp_param.sv
// ---------------------------------------------------------------------------
// ramb_tdp_param
// Parametrised true-dual-port block RAM, one shared clock. Holds the array,
// the lane-merged write path for both ports, collision detection and two
// ramb_port_out instances.
// Ports:
//   CLK, RST_N        : clock (rising edge), async active-low reset
//   ENA/ENB           : port enables
//   WEA/WEB           : per-lane write enables
//   SSRA/SSRB         : sync set/reset of the output to SRVAL_x
//   ADDRA/ADDRB       : word addresses
//   DIA/DIB           : write data
//   DOA/DOB, DVA/DVB  : read data and one-cycle valid
//   COLL              : one-cycle pulse after a same-address access with a write
// ---------------------------------------------------------------------------
module ramb_tdp_param
  import ramb_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 18,
  parameter int                    BYTE_WIDTH   = 9,
  parameter int                    ADDR_WIDTH   = 10,
  parameter string                 WRITE_MODE_A = "WRITE_FIRST",
  parameter string                 WRITE_MODE_B = "WRITE_FIRST",
  parameter int                    DO_REG       = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_A       = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_B       = '0,
  parameter logic [DATA_WIDTH-1:0] SRVAL_A      = '0,
  parameter logic [DATA_WIDTH-1:0] SRVAL_B      = '0
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             ENA,
  input  logic                             ENB,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WEA,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WEB,
  input  logic                             SSRA,
  input  logic                             SSRB,
  input  logic [ADDR_WIDTH-1:0]            ADDRA,
  input  logic [ADDR_WIDTH-1:0]            ADDRB,
  input  logic [DATA_WIDTH-1:0]            DIA,
  input  logic [DATA_WIDTH-1:0]            DIB,
  output logic [DATA_WIDTH-1:0]            DOA,
  output logic [DATA_WIDTH-1:0]            DOB,
  output logic                             DVA,
  output logic                             DVB,
  output logic                             COLL
);

  localparam int          LANES  = DATA_WIDTH / BYTE_WIDTH;
  localparam int          DEPTH  = 2 ** ADDR_WIDTH;
  localparam write_mode_e MODE_A = str_to_mode(WRITE_MODE_A);
  localparam write_mode_e MODE_B = str_to_mode(WRITE_MODE_B);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_width
    $error("ramb_tdp_param: DATA_WIDTH %0d is not a multiple of BYTE_WIDTH %0d",
           DATA_WIDTH, BYTE_WIDTH);
  end
  if (DATA_WIDTH > MAX_DW) begin : g_err_max
    $error("ramb_tdp_param: DATA_WIDTH %0d exceeds %0d", DATA_WIDTH, MAX_DW);
  end
  if (!mode_valid(WRITE_MODE_A)) begin : g_err_mode_a
    $error("ramb_tdp_param: illegal WRITE_MODE_A \"%s\"", WRITE_MODE_A);
  end
  if (!mode_valid(WRITE_MODE_B)) begin : g_err_mode_b
    $error("ramb_tdp_param: illegal WRITE_MODE_B \"%s\"", WRITE_MODE_B);
  end

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] o,
                                                  input logic [DATA_WIDTH-1:0] n,
                                                  input logic [LANES-1:0]      we);
    return DATA_WIDTH'(lane_merge(MAX_DW'(o), MAX_DW'(n), MAX_DW'(we), BYTE_WIDTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] old_a, old_b, word_a, word_b, final_b;
  logic                  wr_a, wr_b, same_addr, coll_q;

  // An X address reads back X from the array in 4-state simulation, and a
  // write through an X index is discarded, so no other word is disturbed.
  assign old_a     = mem[ADDRA];
  assign old_b     = mem[ADDRB];
  assign wr_a      = ENA && (|WEA);
  assign wr_b      = ENB && (|WEB);
  assign same_addr = ENA && ENB && (ADDRA == ADDRB);

  // On a shared address A's lanes are laid over B's merged word: A wins only
  // where WEA is set, B fills its own lanes, untouched lanes keep old data.
  assign word_b  = merge(old_b, DIB, WEB);
  assign word_a  = (same_addr && wr_b) ? merge(word_b, DIA, WEA)
                                       : merge(old_a, DIA, WEA);
  assign final_b = (same_addr && wr_a) ? word_a : word_b;

  // Array is not reset; the reset term only blocks writes while RST_N is low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (RST_N) begin
      if (wr_a) mem[ADDRA] <= word_a;
      if (wr_b && !(same_addr && wr_a)) mem[ADDRB] <= word_b;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) coll_q <= 1'b0;
    else        coll_q <= same_addr && (wr_a || wr_b);
  end

  assign COLL = coll_q;

  // A reader in a collision has wr=0, so it always latches the old word.
  ramb_port_out #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODE       (MODE_A),
    .DO_REG     (DO_REG),
    .INIT       (INIT_A),
    .SRVAL      (SRVAL_A)
  ) u_port_a (
    .clk      (CLK),
    .rst_n    (RST_N),
    .en       (ENA),
    .wr       (wr_a),
    .ssr      (SSRA),
    .old_word (old_a),
    .new_word (word_a),
    .dout     (DOA),
    .dv       (DVA)
  );

  ramb_port_out #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODE       (MODE_B),
    .DO_REG     (DO_REG),
    .INIT       (INIT_B),
    .SRVAL      (SRVAL_B)
  ) u_port_b (
    .clk      (CLK),
    .rst_n    (RST_N),
    .en       (ENB),
    .wr       (wr_b),
    .ssr      (SSRB),
    .old_word (old_b),
    .new_word (final_b),
    .dout     (DOB),
    .dv       (DVB)
  );

endmodule

// File: tb/tb_ramb_tdp_param.sv
// ---------------------------------------------------------------------------
// tb_ramb_tdp_param
// dut0: 1Kx18, A write-first, B read-first, no output register.
// dut1: same inputs as dut0, A no-change, B write-first, output register.
// dut2: 16x32 with 8-bit lanes, default modes.
// ---------------------------------------------------------------------------
module tb_ramb_tdp_param;

  localparam logic [17:0] INIT_A0  = 18'h2AAAA, INIT_B0  = 18'h01234;
  localparam logic [17:0] SRVAL_A0 = 18'h15555, SRVAL_B0 = 18'h00F0F;
  localparam logic [17:0] INIT_A1  = 18'h00123, INIT_B1  = 18'h3FFFF;
  localparam logic [17:0] SRVAL_A1 = 18'h3000F, SRVAL_B1 = 18'h1ABCD;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        ena = 1'b0, enb = 1'b0, ssra = 1'b0, ssrb = 1'b0;
  logic [1:0]  wea = '0, web = '0;
  logic [9:0]  addra = '0, addrb = '0;
  logic [17:0] dia = '0, dib = '0;
  logic [17:0] doa0, dob0, doa1, dob1;
  logic        dva0, dvb0, dva1, dvb1, coll0, coll1;

  logic        ena2 = 1'b0, enb2 = 1'b0;
  logic [3:0]  wea2 = '0, web2 = '0, addra2 = '0, addrb2 = '0;
  logic [31:0] dia2 = '0, dib2 = '0, doa2, dob2;
  logic        dva2, dvb2, coll2;

  always #5 CLK = ~CLK;

  ramb_tdp_param #(
    .WRITE_MODE_A ("WRITE_FIRST"), .WRITE_MODE_B ("READ_FIRST"), .DO_REG (0),
    .INIT_A (INIT_A0), .INIT_B (INIT_B0), .SRVAL_A (SRVAL_A0), .SRVAL_B (SRVAL_B0)
  ) dut0 (
    .CLK (CLK), .RST_N (RST_N), .ENA (ena), .ENB (enb), .WEA (wea), .WEB (web),
    .SSRA (ssra), .SSRB (ssrb), .ADDRA (addra), .ADDRB (addrb), .DIA (dia), .DIB (dib),
    .DOA (doa0), .DOB (dob0), .DVA (dva0), .DVB (dvb0), .COLL (coll0)
  );

  ramb_tdp_param #(
    .WRITE_MODE_A ("NO_CHANGE"), .WRITE_MODE_B ("WRITE_FIRST"), .DO_REG (1),
    .INIT_A (INIT_A1), .INIT_B (INIT_B1), .SRVAL_A (SRVAL_A1), .SRVAL_B (SRVAL_B1)
  ) dut1 (
    .CLK (CLK), .RST_N (RST_N), .ENA (ena), .ENB (enb), .WEA (wea), .WEB (web),
    .SSRA (ssra), .SSRB (ssrb), .ADDRA (addra), .ADDRB (addrb), .DIA (dia), .DIB (dib),
    .DOA (doa1), .DOB (dob1), .DVA (dva1), .DVB (dvb1), .COLL (coll1)
  );

  ramb_tdp_param #(
    .DATA_WIDTH (32), .BYTE_WIDTH (8), .ADDR_WIDTH (4)
  ) dut2 (
    .CLK (CLK), .RST_N (RST_N), .ENA (ena2), .ENB (enb2), .WEA (wea2), .WEB (web2),
    .SSRA (1'b0), .SSRB (1'b0), .ADDRA (addra2), .ADDRB (addrb2), .DIA (dia2), .DIB (dib2),
    .DOA (doa2), .DOB (dob2), .DVA (dva2), .DVB (dvb2), .COLL (coll2)
  );

  // ---------------- reference model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [17:0] mref [1024];
  logic [17:0] lat [2][2];   // [dut][port] output latch
  logic        lv  [2][2];
  logic [17:0] s2  [2];      // dut1 second stage per port
  logic        s2v [2];
  logic        exp_coll;
  logic [31:0] m2 [16];

  // 0 write-first, 1 read-first, 2 no-change
  function automatic int mode_of(input int d, input int p);
    if (d == 0) return (p == 0) ? 0 : 1;
    return (p == 0) ? 2 : 0;
  endfunction

  function automatic logic [17:0] init_v(input int d, input int p);
    if (d == 0) return (p == 0) ? INIT_A0 : INIT_B0;
    return (p == 0) ? INIT_A1 : INIT_B1;
  endfunction

  function automatic logic [17:0] srval_v(input int d, input int p);
    if (d == 0) return (p == 0) ? SRVAL_A0 : SRVAL_B0;
    return (p == 0) ? SRVAL_A1 : SRVAL_B1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        lat[d][p] = init_v(d, p);
        lv[d][p]  = 1'b0;
      end
    for (int p = 0; p < 2; p++) begin
      s2[p]  = init_v(1, p);
      s2v[p] = 1'b0;
    end
    exp_coll = 1'b0;
  endtask

  task automatic model_port(input int mode, input logic en, input logic wr, input logic ssr,
                            input logic [17:0] old_w, input logic [17:0] new_w,
                            input logic [17:0] srv, inout logic [17:0] l, inout logic v);
    if (!en)                    v = 1'b0;
    else if (ssr)               begin l = srv;   v = 1'b0; end
    else if (!wr || mode == 1)  begin l = old_w; v = 1'b1; end
    else if (mode == 0)         begin l = new_w; v = 1'b1; end
    else                        v = 1'b0;
  endtask

  task automatic model_update();
    logic [17:0] old_w [2];
    logic [17:0] new_w [2];
    logic        en_p [2], ssr_p [2], wr_p [2];
    logic        same;
    if (!RST_N) begin
      model_reset();
      return;
    end
    old_w[0] = mref[addra];
    old_w[1] = mref[addrb];
    en_p[0] = ena;  en_p[1] = enb;
    ssr_p[0] = ssra; ssr_p[1] = ssrb;
    wr_p[0] = ena && (wea != 2'b00);
    wr_p[1] = enb && (web != 2'b00);
    same = ena && enb && (addra == addrb);
    for (int i = 0; i < 2; i++) begin
      new_w[0][i*9 +: 9] = (wr_p[0] && wea[i]) ? dia[i*9 +: 9] :
                           (same && wr_p[1] && web[i]) ? dib[i*9 +: 9] : old_w[0][i*9 +: 9];
      new_w[1][i*9 +: 9] = (same && wr_p[0] && wea[i]) ? dia[i*9 +: 9] :
                           (wr_p[1] && web[i]) ? dib[i*9 +: 9] : old_w[1][i*9 +: 9];
    end
    if (wr_p[0]) mref[addra] = new_w[0];
    if (wr_p[1]) mref[addrb] = new_w[1];
    exp_coll = same && (wr_p[0] || wr_p[1]);
    for (int p = 0; p < 2; p++) begin
      if (en_p[p] && ssr_p[p]) begin
        s2[p] = srval_v(1, p); s2v[p] = 1'b0;
      end else begin
        s2[p] = lat[1][p]; s2v[p] = lv[1][p];
      end
    end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        model_port(mode_of(d, p), en_p[p], wr_p[p], ssr_p[p], old_w[p], new_w[p],
                   srval_v(d, p), lat[d][p], lv[d][p]);
  endtask

  // ---------------- checks ----------------
  task automatic chk18(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check01();
    chk18("doa0", doa0, lat[0][0]); chk1("dva0", dva0, lv[0][0]);
    chk18("dob0", dob0, lat[0][1]); chk1("dvb0", dvb0, lv[0][1]);
    chk18("doa1", doa1, s2[0]);     chk1("dva1", dva1, s2v[0]);
    chk18("dob1", dob1, s2[1]);     chk1("dvb1", dvb1, s2v[1]);
    chk1("coll0", coll0, exp_coll); chk1("coll1", coll1, exp_coll);
  endtask

  task automatic step01();
    model_update();
    @(posedge CLK);
    #1;
    check01();
  endtask

  task automatic set_a(input logic en, input logic [1:0] we, input logic ssr,
                       input logic [9:0] addr, input logic [17:0] d);
    ena = en; wea = we; ssra = ssr; addra = addr; dia = d;
  endtask

  task automatic set_b(input logic en, input logic [1:0] we, input logic ssr,
                       input logic [9:0] addr, input logic [17:0] d);
    enb = en; web = we; ssrb = ssr; addrb = addr; dib = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [17:0] d;
    logic [17:0] a_ww, b_ww, exp7;
    logic [9:0]  ra;

    #1 RST_N = 1'b0;
    model_reset();
    #1 check01();
    @(posedge CLK); #1;
    check01();
    RST_N = 1'b1;

    // preload addresses 0..15 through port A
    for (int i = 0; i < 16; i++) begin
      d = 18'($urandom);
      if (i == 3) d = 18'h3FFFF;
      if (i == 5) d = 18'h01234;
      if (i == 9) d = 18'h00155;
      set_a(1'b1, 2'b11, 1'b0, 10'(i), d);
      step01();
    end

    // mid-cycle reset; the edge under reset must not write
    set_a(1'b1, 2'b11, 1'b0, 10'd5, 18'h3FFFF);
    #3 RST_N = 1'b0;
    model_reset();
    #1 check01();
    chk18("rst_doa0_async", doa0, 18'h2AAAA);
    chk1("rst_dva0_async", dva0, 1'b0);
    step01();
    RST_N = 1'b1;
    set_a(1'b1, 2'b00, 1'b0, 10'd5, 18'h0);
    step01();
    chk18("rst_read5", doa0, 18'h01234);

    // write modes: A WF (dut0) / NC (dut1), then B RF (dut0) / WF (dut1)
    set_a(1'b1, 2'b11, 1'b0, 10'd5, 18'h0ABCD);
    step01();
    chk18("wf_doa0", doa0, 18'h0ABCD);
    set_a(1'b1, 2'b11, 1'b0, 10'd5, 18'h01234);
    step01();
    set_a(1'b0, 2'b00, 1'b0, 10'd0, 18'h0);
    set_b(1'b1, 2'b11, 1'b0, 10'd5, 18'h0ABCD);
    step01();
    chk18("rf_dob0", dob0, 18'h01234);
    set_b(1'b0, 2'b00, 1'b0, 10'd0, 18'h0);
    step01();
    chk18("wf_dob1", dob1, 18'h0ABCD);

    // byte lanes: only the lower lane written
    set_a(1'b1, 2'b01, 1'b0, 10'd3, 18'h0);
    step01();
    set_a(1'b1, 2'b00, 1'b0, 10'd3, 18'h0);
    step01();
    chk18("lane_mem3", doa0, 18'h3FE00);

    // collision: both write address 7
    a_ww = 18'h11111;
    b_ww = 18'h22222;
    exp7 = {a_ww[17:9], b_ww[8:0]};
    set_a(1'b1, 2'b10, 1'b0, 10'd7, a_ww);
    set_b(1'b1, 2'b11, 1'b0, 10'd7, b_ww);
    step01();
    chk1("coll_ww", coll0, 1'b1);
    set_a(1'b1, 2'b00, 1'b0, 10'd7, 18'h0);
    set_b(1'b0, 2'b00, 1'b0, 10'd0, 18'h0);
    step01();
    chk18("coll_mem7", doa0, exp7);
    chk1("coll_one_cycle", coll0, 1'b0);

    // collision: A reads, B writes -> A sees old word
    set_b(1'b1, 2'b11, 1'b0, 10'd7, 18'h3C3C3);
    step01();
    chk18("coll_wr_rd_old", doa0, exp7);
    chk1("coll_wr_rd", coll0, 1'b1);
    // both read the same address: no collision
    set_b(1'b1, 2'b00, 1'b0, 10'd7, 18'h0);
    step01();
    chk1("coll_rd_rd", coll0, 1'b0);

    // output register stage with SSRB on dut1
    set_a(1'b0, 2'b00, 1'b0, 10'd0, 18'h0);
    set_b(1'b1, 2'b00, 1'b0, 10'd9, 18'h0);
    step01();
    set_b(1'b0, 2'b00, 1'b0, 10'd0, 18'h0);
    step01();
    chk18("doreg_dob1", dob1, 18'h00155);
    chk1("doreg_dvb1", dvb1, 1'b1);
    set_b(1'b1, 2'b00, 1'b1, 10'd9, 18'h0);
    step01();
    chk18("ssr_dob1", dob1, SRVAL_B1);
    chk1("ssr_dvb1", dvb1, 1'b0);

    // randomized traffic on addresses 0..15, frequent collisions
    for (int k = 0; k < 300; k++) begin
      ra = 10'($urandom_range(0, 15));
      set_a(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 7) == 0),
            ra, 18'($urandom));
      set_b(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0) ? ra : 10'($urandom_range(0, 15)), 18'($urandom));
      step01();
    end
    set_a(1'b0, 2'b00, 1'b0, 10'd0, 18'h0);
    set_b(1'b0, 2'b00, 1'b0, 10'd0, 18'h0);

    // 16x32 sweep: fill via A, partial write through wrapped address, read via B
    for (int i = 0; i < 16; i++) begin
      ena2 = 1'b1; wea2 = 4'hF; addra2 = 4'(i); dia2 = $urandom;
      m2[i] = dia2;
      @(posedge CLK); #1;
      chk32("sweep_wr_doa2", doa2, m2[i]);
      chk1("sweep_wr_dva2", dva2, 1'b1);
    end
    addra2 = 4'd15;
    addra2 = addra2 + 4'd1;
    wea2 = 4'b0101;
    dia2 = $urandom;
    for (int l = 0; l < 4; l++)
      if (wea2[l]) m2[0][l*8 +: 8] = dia2[l*8 +: 8];
    @(posedge CLK); #1;
    chk32("sweep_lane_wrap", doa2, m2[0]);
    ena2 = 1'b0; wea2 = 4'h0;
    addrb2 = 4'd0;
    for (int j = 0; j < 18; j++) begin
      enb2 = 1'b1;
      @(posedge CLK); #1;
      chk32("sweep_rd_dob2", dob2, m2[j % 16]);
      chk1("sweep_rd_dvb2", dvb2, 1'b1);
      chk1("sweep_coll2", coll2, 1'b0);
      addrb2 = addrb2 + 4'd1;
    end
    enb2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
